pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

Reset sequencer sitting directly downstream of the fabric PLL, clocked by the free-running 50 MHz board reference. It drives the PLL's reset input and watches its `locked` output. It re-resets the PLL when lock does not arrive within a timeout. Once lock is stable, it releases three per-subsystem resets in a fixed order: DDR3 controller, then camera interface, then HDMI output. Any later loss of lock re-asserts all resets and restarts the sequence.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the `locked` synchronizer (minimum 2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (minimum 1).
- `LOCK_TIMEOUT`, 50000: cycles to wait for synchronized lock before retrying (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive cycles of synchronized lock required before any release.
- `STAGE_GAP`, 256: cycles between successive `rst_out` releases.

Ports (one clock; reset is synchronous and active-high):
- `refclk`, input, 1: clock, the 50 MHz board reference (not a PLL output).
- `rst`, input, 1: synchronous active-high reset.
- `locked`, input, 1: PLL lock indicator, asynchronous to `refclk`.
- `pll_rst`, output, 1: reset to the PLL, active-high.
- `rst_out`, output, 3: active-high subsystem resets. Bit 0 is DDR3, bit 1 is camera (24 MHz XCLK domain), bit 2 is HDMI (75 MHz).
- `sys_ready`, output, 1: high when all resets are released and lock is held.
- `retry_cnt`, output, 8: saturating count of lock timeouts.
- `loss_cnt`, output, 8: saturating count of lock losses after stable lock.

## Operation
- `locked` passes through a `SYNC_STAGES` flop chain to form `locked_s`. Nothing else reads raw `locked`.
- One down/up counter `cnt`, sized for the largest parameter, is shared by all states and cleared on every state transition.
- **PLL_RST** (entered at reset):
  - `pll_rst`=1 and `rst_out`=3'b111.
  - After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK**:
  - `pll_rst`=0.
  - If `locked_s`=1, go to STABLE.
  - Else, if `cnt` reaches `LOCK_TIMEOUT`-1, increment `retry_cnt` (saturating at 255) and go to PLL_RST.
- **STABLE**:
  - If `locked_s` falls, go back to WAIT_LOCK with `cnt` cleared. This is not counted as a loss or a retry.
  - After `STABLE_CYCLES` consecutive cycles with `locked_s`=1, go to RELEASE.
- **RELEASE**:
  - `rst_out[0]` clears on entry.
  - `rst_out[1]` clears `STAGE_GAP` cycles after entry.
  - At 2·`STAGE_GAP` cycles after entry, go to RUN.
- **RUN**:
  - `rst_out`=3'b000 and `sys_ready`=1.
- **Lock loss**: in RELEASE or RUN, `locked_s`=0 does all of the following, with no further condition:
  - in the same cycle, `rst_out`=3'b111 and `sys_ready`=0;
  - increments `loss_cnt` (saturating);
  - transitions to PLL_RST.
- Released resets never re-assert individually. Re-assertion is always all three bits together.
- Both counters saturate at 8'hFF and clear only on `rst`.

## Timing
- All outputs are registered and change only on the rising edge of `refclk`.
- Reset values while `rst`=1: `pll_rst`=1, `rst_out`=3'b111, `sys_ready`=0, `retry_cnt`=0, `loss_cnt`=0, synchronizer flops 0, state PLL_RST.
- Cycle 0 is the first edge with `rst` sampled low.
  - `pll_rst` stays high through cycle `PLL_RST_CYCLES`-1 and is low from cycle `PLL_RST_CYCLES`.
- A `locked` rise set up before edge E is seen as `locked_s`=1 at edge E+`SYNC_STAGES`-1.
  - The STABLE transition happens on the following edge.
- STABLE→RELEASE occurs exactly `STABLE_CYCLES` cycles after STABLE entry.
  - `rst_out[0]` is low from that edge.
- Release schedule, with T = the RELEASE-entry edge:
  - `rst_out[1]` is low from T+`STAGE_GAP`.
  - `rst_out[2]` and `sys_ready` change together at T+2·`STAGE_GAP`.
- Lock-loss response latency: `rst_out` and `sys_ready` react one edge after `locked_s` falls, which is `SYNC_STAGES` edges after raw `locked` falls.
- `rst` asserted mid-sequence: all outputs return to reset values on the next edge, including counters.
- Simultaneous events:
  - A timeout edge that coincides with `locked_s` rising takes STABLE, with no retry counted.
  - `locked_s` falling on the final STABLE cycle returns to WAIT_LOCK, with no release.

## Test plan
Common parameters: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `STAGE_GAP`=5. `locked` is driven synchronously.

1. **Clean lock.** Release `rst`; raise `locked` before edge 10 and hold it.
   - `pll_rst` is high for cycles 0–3.
   - `rst_out[0]` is low at cycle 20 and `rst_out[1]` is low at 25.
   - `rst_out[2]` is low and `sys_ready`=1 at 30.
   - Both counters remain 0.
2. **Lock timeout.** Hold `locked`=0 for 60 cycles.
   - `pll_rst` re-pulses for 4 cycles after every 20 WAIT_LOCK cycles.
   - `retry_cnt`=2 at cycle 60.
   - `rst_out` is 3'b111 throughout.
3. **Glitch during STABLE.** Drop `locked` for 1 cycle, 5 cycles into STABLE.
   - No release occurs and no counter changes.
   - The release happens 8 full cycles after the re-lock is seen.
4. **Loss in RUN.** In RUN, drop `locked`.
   - Two edges later: `rst_out`=3'b111, `sys_ready`=0, `loss_cnt`=1, `pll_rst`=1.
   - Re-locking repeats the scenario-1 schedule.
5. **Mid-RELEASE reset.** Assert `rst` at T+3.
   - The next edge restores all reset values, including `retry_cnt`/`loss_cnt`=0.
6. **Saturation.** Hold `locked`=0 for 300 timeouts.
   - `retry_cnt` stops at 8'hFF and does not wrap.

Source files
------------

// File: rtl/pll_rst_seq_if.sv
// Signal bundle between the reset sequencer and the PLL and subsystem
// resets it controls. master = sequencer side, slave = PLL/consumer side.
// All signals are plain levels; there is no valid/ready handshake here.
interface pll_rst_seq_if;
    logic       locked;     // raw PLL lock, asynchronous to refclk
    logic       pll_rst;    // active-high reset into the PLL
    logic [2:0] rst_out;    // [0] DDR3, [1] camera, [2] HDMI; active-high
    logic       sys_ready;  // all resets released and lock held
    logic [7:0] retry_cnt;  // saturating count of lock timeouts
    logic [7:0] loss_cnt;   // saturating count of losses after stable lock

    modport master (
        input  locked,
        output pll_rst,
        output rst_out,
        output sys_ready,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  rst_out,
        input  sys_ready,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock (retrying on
// timeout), requires a stable lock window, then releases DDR3, camera and
// HDMI resets in order. Any loss of lock after release re-asserts all three
// resets together and restarts from a fresh PLL reset pulse.
module pll_rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP      = 256
) (
    input  logic              refclk,
    input  logic              rst,
    pll_rst_seq_if.master     bus,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // The shared counter must hold the largest terminal value; one spare bit
    // keeps the all-ones reset preload distinct from every terminal value.
    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (STABLE_CYCLES > 2 * STAGE_GAP) ? STABLE_CYCLES : 2 * STAGE_GAP;
    localparam int MAX_V  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_V + 1) + 1;

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP1_LAST   = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] GAP2_LAST   = CW'(2 * STAGE_GAP - 1);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   pll_rst_q;
    logic [2:0]             rst_out_q;
    logic                   sys_ready_q;
    logic [7:0]             retry_q;
    logic [7:0]             loss_q;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign cnt_d    = cnt_q + CNT_ONE;

    assign bus.pll_rst   = pll_rst_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.sys_ready = sys_ready_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;
    assign state_o       = state_q;

    // Bring raw lock into the refclk domain; only locked_s is used below.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
        end
    end

    // Sequencer FSM with registered outputs; cnt restarts on every transition.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_PLL_RST;
            // Reset acts as the cycle before PLL_RST entry: the counter wraps
            // to zero on cycle 0 so the pulse lasts PLL_RST_CYCLES after rst.
            cnt_q       <= '1;
            pll_rst_q   <= 1'b1;
            rst_out_q   <= 3'b111;
            sys_ready_q <= 1'b0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_LAST) begin
                        state_q   <= ST_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (locked_s) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q   <= ST_PLL_RST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q != 8'hFF) begin
                            retry_q <= retry_q + 8'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    // A dropout before the window completes just re-waits.
                    if (!locked_s) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q   <= ST_RELEASE;
                        cnt_q     <= '0;
                        rst_out_q <= 3'b110;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_q     <= ST_PLL_RST;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        rst_out_q   <= 3'b111;
                        sys_ready_q <= 1'b0;
                        if (loss_q != 8'hFF) begin
                            loss_q <= loss_q + 8'd1;
                        end
                    end else if (cnt_q == GAP2_LAST) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        rst_out_q   <= 3'b000;
                        sys_ready_q <= 1'b1;
                    end else if (cnt_q == GAP1_LAST) begin
                        rst_out_q[1] <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_q     <= ST_PLL_RST;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        rst_out_q   <= 3'b111;
                        sys_ready_q <= 1'b0;
                        if (loss_q != 8'hFF) begin
                            loss_q <= loss_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_PLL_RST;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    rst_out_q   <= 3'b111;
                    sys_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: a deadline-based model (phase plus entry edge) runs
// alongside the DUT and every cycle's expected outputs are queued and checked;
// directed scenarios add literal checks at hand-computed cycles.
module tb_pll_rst_seq;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int G  = 5;
    localparam int EW = 21;

    localparam int PH_PLL = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_REL = 3;
    localparam int PH_RUN = 4;

    logic       refclk;
    logic       rst;
    logic [2:0] state_dbg;

    pll_rst_seq_if bus();

    pll_rst_seq #(
        .SYNC_STAGES(S), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC), .STAGE_GAP(G)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .bus(bus.master),
        .state_o(state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int vectors = 0;
    int errors  = 0;
    int cyc     = -1;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h required %0h", nm, cyc, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   n_edge  = 0;
    int   m_phase = PH_PLL;
    int   m_t0    = 0;
    int   m_retry = 0;
    int   m_loss  = 0;
    bit   m_valid = 0;
    logic hist [0:S-1];

    task automatic enter(input int ph);
        m_phase = ph;
        m_t0    = n_edge;
    endtask

    task automatic model_step();
        logic ls;
        int a;
        logic       e_pll;
        logic [2:0] e_ro;
        logic       e_rdy;
        if (rst) begin
            m_phase = PH_PLL;
            m_t0    = n_edge + 1;
            m_retry = 0;
            m_loss  = 0;
            for (int i = 0; i < S; i++) hist[i] = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            ls = hist[S-1];
            a  = n_edge - m_t0;
            case (m_phase)
                PH_PLL:    if (a == P) enter(PH_WAIT);
                PH_WAIT: begin
                    if (ls) enter(PH_STABLE);
                    else if (a == LT) begin
                        if (m_retry < 255) m_retry++;
                        enter(PH_PLL);
                    end
                end
                PH_STABLE: begin
                    if (!ls) enter(PH_WAIT);
                    else if (a == SC) enter(PH_REL);
                end
                PH_REL: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        enter(PH_PLL);
                    end else if (a == 2 * G) enter(PH_RUN);
                end
                default: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        enter(PH_PLL);
                    end
                end
            endcase
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.locked;
        end
        if (m_valid) begin
            a     = n_edge - m_t0;
            e_pll = (m_phase == PH_PLL);
            e_rdy = (m_phase == PH_RUN);
            if (m_phase == PH_RUN)      e_ro = 3'b000;
            else if (m_phase == PH_REL) e_ro = {1'b1, (a < G), 1'b0};
            else                        e_ro = 3'b111;
            exp_q.push_back({e_pll, e_ro, e_rdy, 8'(m_retry), 8'(m_loss)});
        end
        n_edge++;
    endtask

    initial begin
        forever begin
            @(posedge refclk);
            model_step();
        end
    end

    // Compare process: one expected vector per edge, checked on the falling edge.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pll_rst",   32'(bus.pll_rst),   32'(e[20]));
                check("rst_out",   32'(bus.rst_out),   32'(e[19:17]));
                check("sys_ready", 32'(bus.sys_ready), 32'(e[16]));
                check("retry_cnt", 32'(bus.retry_cnt), 32'(e[15:8]));
                check("loss_cnt",  32'(bus.loss_cnt),  32'(e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic r, input logic l);
        @(negedge refclk);
        rst        = r;
        bus.locked = l;
        @(posedge refclk);
        #1;
        if (r) cyc = -1;
        else   cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   run_len;
        logic lv;
        rst        = 1'b1;
        bus.locked = 1'b0;

        // Clean lock, then loss in RUN and re-lock.
        do_reset(3);
        check("reset_state", 32'(state_dbg), 32'd0);
        check("reset_rst_out", 32'(bus.rst_out), 32'h7);
        for (int k = 0; k <= 65; k++) begin
            cycle(1'b0, (k >= 10) && !(k >= 36 && k <= 38));
            if (k == 3)  check("s1_pll_hi_c3", 32'(bus.pll_rst), 32'd1);
            if (k == 4)  check("s1_pll_lo_c4", 32'(bus.pll_rst), 32'd0);
            if (k == 19) check("s1_ro_c19", 32'(bus.rst_out), 32'h7);
            if (k == 20) check("s1_ro_c20", 32'(bus.rst_out), 32'h6);
            if (k == 24) check("s1_ro_c24", 32'(bus.rst_out), 32'h6);
            if (k == 25) check("s1_ro_c25", 32'(bus.rst_out), 32'h4);
            if (k == 29) check("s1_rdy_c29", 32'(bus.sys_ready), 32'd0);
            if (k == 30) begin
                check("s1_ro_c30", 32'(bus.rst_out), 32'h0);
                check("s1_rdy_c30", 32'(bus.sys_ready), 32'd1);
                check("s1_cnts", 32'({bus.retry_cnt, bus.loss_cnt}), 32'h0);
            end
            if (k == 37) check("s4_rdy_c37", 32'(bus.sys_ready), 32'd1);
            if (k == 38) begin
                check("s4_ro_c38", 32'(bus.rst_out), 32'h7);
                check("s4_rdy_c38", 32'(bus.sys_ready), 32'd0);
                check("s4_loss_c38", 32'(bus.loss_cnt), 32'd1);
                check("s4_pll_c38", 32'(bus.pll_rst), 32'd1);
            end
            if (k == 50) check("s4_ro_c50", 32'(bus.rst_out), 32'h7);
            if (k == 51) check("s4_ro_c51", 32'(bus.rst_out), 32'h6);
            if (k == 61) check("s4_rdy_c61", 32'(bus.sys_ready), 32'd1);
        end

        // Lock timeout.
        do_reset(2);
        for (int k = 0; k <= 60; k++) begin
            cycle(1'b0, 1'b0);
            if (k == 23) check("s2_pll_c23", 32'(bus.pll_rst), 32'd0);
            if (k == 24) begin
                check("s2_pll_c24", 32'(bus.pll_rst), 32'd1);
                check("s2_retry_c24", 32'(bus.retry_cnt), 32'd1);
            end
            if (k == 27) check("s2_pll_c27", 32'(bus.pll_rst), 32'd1);
            if (k == 28) check("s2_pll_c28", 32'(bus.pll_rst), 32'd0);
            if (k == 60) begin
                check("s2_retry_c60", 32'(bus.retry_cnt), 32'd2);
                check("s2_ro_c60", 32'(bus.rst_out), 32'h7);
            end
        end

        // Glitch during STABLE (STABLE entered at cycle 12, glitch at edge 17).
        do_reset(2);
        for (int k = 0; k <= 35; k++) begin
            cycle(1'b0, (k >= 10) && (k != 17));
            if (k == 20) check("s3_ro_c20", 32'(bus.rst_out), 32'h7);
            if (k == 27) check("s3_ro_c27", 32'(bus.rst_out), 32'h7);
            if (k == 28) begin
                check("s3_ro_c28", 32'(bus.rst_out), 32'h6);
                check("s3_cnts", 32'({bus.retry_cnt, bus.loss_cnt}), 32'h0);
            end
        end

        // Mid-RELEASE reset: one timeout first, RELEASE entered at cycle 40.
        do_reset(2);
        for (int k = 0; k <= 42; k++) begin
            cycle(1'b0, k >= 30);
            if (k == 42) begin
                check("s5_retry_c42", 32'(bus.retry_cnt), 32'd1);
                check("s5_ro_c42", 32'(bus.rst_out), 32'h6);
            end
        end
        cycle(1'b1, 1'b1);
        check("s5_rst_ro", 32'(bus.rst_out), 32'h7);
        check("s5_rst_pll", 32'(bus.pll_rst), 32'd1);
        check("s5_rst_rdy", 32'(bus.sys_ready), 32'd0);
        check("s5_rst_retry", 32'(bus.retry_cnt), 32'd0);

        // Saturation: 300 timeouts at 24 cycles each.
        do_reset(2);
        for (int k = 0; k < 300 * (LT + P) + 10; k++) cycle(1'b0, 1'b0);
        check("s6_retry_sat", 32'(bus.retry_cnt), 32'hFF);

        // Randomized lock behaviour with occasional resets.
        do_reset(2);
        run_len = 0;
        lv      = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (run_len == 0) begin
                lv      = 1'($urandom_range(0, 1));
                run_len = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
            end
            run_len--;
            cycle(($urandom_range(0, 399) == 0), lv);
        end

        @(negedge refclk);
        @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
